// File: rtl/gate_vector_sequencer_if.sv
// Bus between the vector sequencer and the gate cell it exercises.
// master = sequencer side, slave = requester / gate side.
interface gate_vector_sequencer_if #(
    parameter int unsigned N_IN = 2
);
    logic              start;
    logic              dut_out;
    logic [N_IN-1:0]   stim;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_fail;

    modport master (
        input  start, dut_out,
        output stim, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, dut_out,
        input  stim, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Walks every input combination of a small gate, holds each for DWELL cycles,
// and checks the gate output against TRUTH on the last cycle of each vector.
module gate_vector_sequencer #(
    parameter int unsigned           N_IN  = 2,
    parameter int unsigned           DWELL = 10,
    parameter logic [(2**N_IN)-1:0]  TRUTH = 4'b1000
) (
    input  logic                    clk,
    input  logic                    rst,
    gate_vector_sequencer_if.master bus
);
    localparam int unsigned NV = 2**N_IN;
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ff_d    = '0;
                    vec_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    if (bus.dut_out != TRUTH[vec_q]) begin
                        err_d = err_q + (N_IN+1)'(1);
                        if (err_q == '0) ff_d = vec_q;
                    end
                    cnt_d = '0;
                    if (vec_q == N_IN'(NV - 1)) begin
                        // pass uses err_d so the final vector's compare is included
                        state_d = IDLE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign bus.stim       = vec_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboard bench: instance A runs DWELL=10, instance B runs DWELL=1 with start held.
module tb_gate_vector_sequencer;
    localparam logic [3:0] TRUTH_TB = 4'b1000;

    typedef struct {
        logic [2:0] err;
        logic [1:0] ff;
        logic       pass;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mode_a = 0;
    int   mode_b = 2;

    logic [1:0] stim_qa[$];
    logic [1:0] stim_qb[$];
    res_t       res_qa[$];
    res_t       res_qb[$];
    logic       done_prev_a = 1'b0;
    logic       done_prev_b = 1'b0;

    gate_vector_sequencer_if #(.N_IN(2)) bus_a ();
    gate_vector_sequencer_if #(.N_IN(2)) bus_b ();

    gate_vector_sequencer #(.N_IN(2), .DWELL(10), .TRUTH(4'b1000)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master)
    );
    gate_vector_sequencer #(.N_IN(2), .DWELL(1), .TRUTH(4'b1000)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master)
    );

    function automatic logic gate_fn(input int mode, input logic a, input logic b);
        case (mode)
            0:       return a & b;
            1:       return a | b;
            default: return 1'b0;
        endcase
    endfunction

    assign bus_a.dut_out = gate_fn(mode_a, bus_a.stim[1], bus_a.stim[0]);
    assign bus_b.dut_out = gate_fn(mode_b, bus_b.stim[1], bus_b.stim[0]);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Producer side of the scoreboard: expected stim per cycle and final verdict.
    task automatic expect_run(input bit on_b, input int mode);
        res_t r;
        logic [1:0] v2;
        logic got;
        int dwell;
        dwell = on_b ? 1 : 10;
        r.err = '0;
        r.ff = '0;
        for (int v = 0; v < 4; v++) begin
            v2 = 2'(v);
            got = gate_fn(mode, v2[1], v2[0]);
            if (got !== TRUTH_TB[v]) begin
                if (r.err == 0) r.ff = v2;
                r.err = r.err + 3'd1;
            end
            for (int d = 0; d < dwell; d++) begin
                if (on_b) stim_qb.push_back(v2);
                else stim_qa.push_back(v2);
            end
        end
        r.pass = (r.err == 0);
        if (on_b) res_qb.push_back(r);
        else res_qa.push_back(r);
    endtask

    task automatic pulse_start_a(output int t0);
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        bus_a.start = 1'b0;
    endtask

    task automatic wait_done_a(output int at);
        int n;
        n = 0;
        while (bus_a.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        at = (bus_a.done === 1'b1) ? cyc : -1;
    endtask

    // Consumer side for instance A.
    always @(negedge clk) begin
        res_t r;
        logic [1:0] e;
        if (bus_a.busy === 1'b1) begin
            checks++;
            if (stim_qa.size() == 0) begin
                errors++;
                $display("FAIL stim_a unexpected busy cycle: stim=%0d expected none", bus_a.stim);
            end else begin
                e = stim_qa.pop_front();
                if (bus_a.stim !== e) begin
                    errors++;
                    $display("FAIL stim_a at cyc %0d: got %0d expected %0d", cyc, bus_a.stim, e);
                end
            end
        end
        if (bus_a.done === 1'b1 && done_prev_a === 1'b0) begin
            checks++;
            if (res_qa.size() == 0) begin
                errors++;
                $display("FAIL result_a unexpected done at cyc %0d", cyc);
            end else begin
                r = res_qa.pop_front();
                if (bus_a.err_count !== r.err || bus_a.first_fail !== r.ff || bus_a.pass !== r.pass) begin
                    errors++;
                    $display("FAIL result_a: got err=%0d ff=%0d pass=%0b expected err=%0d ff=%0d pass=%0b",
                             bus_a.err_count, bus_a.first_fail, bus_a.pass, r.err, r.ff, r.pass);
                end
            end
        end
        done_prev_a <= bus_a.done;
    end

    // Consumer side for instance B.
    always @(negedge clk) begin
        res_t r;
        logic [1:0] e;
        if (bus_b.busy === 1'b1) begin
            checks++;
            if (stim_qb.size() == 0) begin
                errors++;
                $display("FAIL stim_b unexpected busy cycle: stim=%0d expected none", bus_b.stim);
            end else begin
                e = stim_qb.pop_front();
                if (bus_b.stim !== e) begin
                    errors++;
                    $display("FAIL stim_b at cyc %0d: got %0d expected %0d", cyc, bus_b.stim, e);
                end
            end
        end
        if (bus_b.done === 1'b1 && done_prev_b === 1'b0) begin
            checks++;
            if (res_qb.size() == 0) begin
                errors++;
                $display("FAIL result_b unexpected done at cyc %0d", cyc);
            end else begin
                r = res_qb.pop_front();
                if (bus_b.err_count !== r.err || bus_b.first_fail !== r.ff || bus_b.pass !== r.pass) begin
                    errors++;
                    $display("FAIL result_b: got err=%0d ff=%0d pass=%0b expected err=%0d ff=%0d pass=%0b",
                             bus_b.err_count, bus_b.first_fail, bus_b.pass, r.err, r.ff, r.pass);
                end
            end
        end
        done_prev_b <= bus_b.done;
    end

    task automatic test_reset;
        rst = 1'b1;
        bus_a.start = 1'b1;
        bus_b.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.first_fail} !== 10'd0) begin
            errors++;
            $display("FAIL reset_a: outputs %b expected all zero (rst beats start)",
                     {bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.first_fail});
        end
        checks++;
        if ({bus_b.stim, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count, bus_b.first_fail} !== 10'd0) begin
            errors++;
            $display("FAIL reset_b: outputs %b expected all zero",
                     {bus_b.stim, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count, bus_b.first_fail});
        end
        bus_a.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_and_basic;
        int t0, at;
        mode_a = 0;
        expect_run(1'b0, 0);
        pulse_start_a(t0);
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
            errors++;
            $display("FAIL and_accept: busy=%0b done=%0b expected busy=1 done=0", bus_a.busy, bus_a.done);
        end
        wait_done_a(at);
        checks++;
        if (at != t0 + 40) begin
            errors++;
            $display("FAIL and_done_time: got %0d expected %0d", at, t0 + 40);
        end
        checks++;
        if (bus_a.pass !== 1'b1 || bus_a.err_count !== 3'd0 || bus_a.busy !== 1'b0 || bus_a.stim !== 2'd0) begin
            errors++;
            $display("FAIL and_verdict: pass=%0b err=%0d busy=%0b stim=%0d expected 1 0 0 0",
                     bus_a.pass, bus_a.err_count, bus_a.busy, bus_a.stim);
        end
    endtask

    task automatic test_or_gate;
        int t0, at;
        mode_a = 1;
        expect_run(1'b0, 1);
        pulse_start_a(t0);
        checks++;
        if (bus_a.done !== 1'b0 || bus_a.pass !== 1'b0 || bus_a.err_count !== 3'd0) begin
            errors++;
            $display("FAIL restart_clear: done=%0b pass=%0b err=%0d expected 0 0 0",
                     bus_a.done, bus_a.pass, bus_a.err_count);
        end
        wait_done_a(at);
        checks++;
        if (at != t0 + 40 || bus_a.err_count !== 3'd2 || bus_a.first_fail !== 2'd1 || bus_a.pass !== 1'b0) begin
            errors++;
            $display("FAIL or_gate: at=%0d err=%0d ff=%0d pass=%0b expected at=%0d err=2 ff=1 pass=0",
                     at, bus_a.err_count, bus_a.first_fail, bus_a.pass, t0 + 40);
        end
    endtask

    task automatic test_stuck0;
        int t0, at;
        mode_a = 2;
        expect_run(1'b0, 2);
        pulse_start_a(t0);
        wait_done_a(at);
        checks++;
        if (at != t0 + 40 || bus_a.err_count !== 3'd1 || bus_a.first_fail !== 2'd3 || bus_a.pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck0: at=%0d err=%0d ff=%0d pass=%0b expected at=%0d err=1 ff=3 pass=0",
                     at, bus_a.err_count, bus_a.first_fail, bus_a.pass, t0 + 40);
        end
    endtask

    task automatic test_start_while_busy;
        int t0, at;
        mode_a = 0;
        expect_run(1'b0, 0);
        pulse_start_a(t0);
        repeat (14) @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_done_a(at);
        checks++;
        if (at != t0 + 40 || bus_a.pass !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: done at %0d pass=%0b expected at %0d pass=1", at, bus_a.pass, t0 + 40);
        end
    endtask

    task automatic test_reset_mid_run;
        int t0, at;
        mode_a = 0;
        expect_run(1'b0, 0);
        pulse_start_a(t0);
        repeat (24) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.first_fail} !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset: outputs %b expected all zero",
                     {bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.first_fail});
        end
        stim_qa.delete();
        res_qa.delete();
        rst = 1'b0;
        expect_run(1'b0, 0);
        pulse_start_a(t0);
        wait_done_a(at);
        checks++;
        if (at != t0 + 40 || bus_a.pass !== 1'b1 || bus_a.err_count !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_run: at=%0d pass=%0b err=%0d expected at=%0d pass=1 err=0",
                     at, bus_a.pass, bus_a.err_count, t0 + 40);
        end
    endtask

    task automatic test_dwell1_held;
        int t0, n;
        mode_b = 2;
        for (int r = 0; r < 3; r++) expect_run(1'b1, 2);
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (bus_b.done !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bus_b.done !== 1'b1 || cyc != t0 + r*5 + 4) begin
                errors++;
                $display("FAIL dwell1_done run %0d: done=%0b at %0d expected 1 at %0d",
                         r, bus_b.done, cyc, t0 + r*5 + 4);
            end
            @(negedge clk);
            if (r < 2) begin
                checks++;
                if (bus_b.done !== 1'b0 || bus_b.busy !== 1'b1 || bus_b.err_count !== 3'd0) begin
                    errors++;
                    $display("FAIL dwell1_restart run %0d: done=%0b busy=%0b err=%0d expected 0 1 0",
                             r, bus_b.done, bus_b.busy, bus_b.err_count);
                end
                if (r == 1) bus_b.start = 1'b0;
            end else begin
                checks++;
                if (bus_b.done !== 1'b1 || bus_b.busy !== 1'b0 || bus_b.err_count !== 3'd1) begin
                    errors++;
                    $display("FAIL dwell1_sticky: done=%0b busy=%0b err=%0d expected 1 0 1",
                             bus_b.done, bus_b.busy, bus_b.err_count);
                end
            end
        end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        test_reset();
        test_and_basic();
        test_or_gate();
        test_stuck0();
        test_start_while_busy();
        test_reset_mid_run();
        test_dwell1_held();
        repeat (2) @(negedge clk);
        checks++;
        if (stim_qa.size() != 0 || res_qa.size() != 0 || stim_qb.size() != 0 || res_qb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left %0d/%0d/%0d/%0d expected 0/0/0/0",
                     stim_qa.size(), res_qa.size(), stim_qb.size(), res_qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
